// File: rtl/ltc2308_pkg.sv
// ---------------------------------------------------------------------------
// ltc2308_pkg
// Shared definitions for the LTC2308 periodic sampler:
//   - state_t     : sampler frame states (IDLE, CONV, XFER, DONE)
//   - CFG_*       : fixed bits of the 6-bit LTC2308 configuration word
//   - ADC_BITS    : result width of the converter
//   - cfg_word()  : maps a single-ended channel number to the config word
// ---------------------------------------------------------------------------
package ltc2308_pkg;

   localparam int ADC_BITS = 12;
   localparam int CFG_BITS = 6;

   // Single-ended, unipolar, sleep disabled.
   localparam logic CFG_SD  = 1'b1;
   localparam logic CFG_UNI = 1'b1;
   localparam logic CFG_SLP = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   // The LTC2308 channel select is not a plain binary field: O/S carries
   // the channel LSB, followed by S1 (bit 2) and S0 (bit 1).
   function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch);
      return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP};
   endfunction

endpackage

// File: rtl/sample_avg4.sv
// ---------------------------------------------------------------------------
// sample_avg4
// Four-sample moving average with a running sum.
// The first sample loaded after reset fills the whole history so the output
// starts at that sample instead of ramping up from zero.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   load    in   accept `sample` this cycle
//   sample  in   new unsigned sample
//   avg     out  (sum of last four samples) >> 2, truncated; valid the
//                cycle after `load`
// ---------------------------------------------------------------------------
module sample_avg4
   import ltc2308_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [ADC_BITS-1:0] sample,
   output logic [ADC_BITS-1:0] avg
);

   logic [ADC_BITS-1:0] hist_reg [4];
   logic [1:0]          ptr_reg;      // entry holding the oldest sample
   logic                primed_reg;
   logic [ADC_BITS+1:0] sum_reg;      // 4 * 4095 fits in 14 bits

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            hist_reg[i] <= '0;
         end
         ptr_reg    <= '0;
         primed_reg <= 1'b0;
         sum_reg    <= '0;
      end else if (load) begin
         for (int i = 0; i < 4; i++) begin
            if (!primed_reg || (ptr_reg == 2'(i))) begin
               hist_reg[i] <= sample;
            end
         end
         if (!primed_reg) begin
            sum_reg    <= {sample, 2'b00};
            primed_reg <= 1'b1;
         end else begin
            sum_reg <= sum_reg - {2'b00, hist_reg[ptr_reg]} + {2'b00, sample};
            ptr_reg <= ptr_reg + 2'd1;
         end
      end
   end

   assign avg = sum_reg[ADC_BITS+1:2];

endmodule

// File: rtl/ltc2308_sampler.sv
// ---------------------------------------------------------------------------
// ltc2308_sampler
// Periodically starts an LTC2308 conversion, shifts the 12-bit result out
// over SPI and presents it as a held value with a one-cycle strobe.
// The first completed frame after reset is discarded because the ADC applies
// a config word to the following conversion.
//
// Optional feature: define SAMPLER_AVG_EN to present a 4-sample moving
// average instead of the raw sample (same latency and strobe timing).
//
// Parameters:
//   CLK_DIV        SCK half-period in clocks (>= 1)
//   CONV_CYCLES    CONVST high time in clocks
//   SAMPLE_PERIOD  clocks between frame starts
//   CHANNEL        single-ended input channel 0..7
// Ports:
//   CLOCK_50      in   system clock
//   RESET_N       in   asynchronous active-low reset
//   ADC_CONVST    out  conversion start
//   ADC_SCK       out  SPI clock, idles low
//   ADC_SDI       out  config word, MSB first
//   ADC_SDO       in   conversion result, MSB first
//   ADC_value     out  last accepted sample, held between updates
//   sample_valid  out  one-cycle pulse when ADC_value updates
// ---------------------------------------------------------------------------
module ltc2308_sampler
   import ltc2308_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int CONV_CYCLES   = 80,
   parameter int SAMPLE_PERIOD = 50000,
   parameter int CHANNEL       = 0
)(
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   output logic                ADC_CONVST,
   output logic                ADC_SCK,
   output logic                ADC_SDI,
   input  logic                ADC_SDO,
   output logic [ADC_BITS-1:0] ADC_value,
   output logic                sample_valid
);

   localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
   localparam int            FRAME_LEN   = CONV_CYCLES + 24 * CLK_DIV + 2;

   // Full 12-period SDI pattern: config word, then zeros.
   localparam logic [ADC_BITS-1:0] SDI_WORD = {cfg_word(3'(CHANNEL)), 6'b000000};

   state_t              state_reg,  state_next;
   logic [PW-1:0]       period_reg;
   logic [CW-1:0]       conv_reg,   conv_next;
   logic [DW-1:0]       div_reg,    div_next;
   logic [3:0]          bit_reg,    bit_next;
   logic                sck_reg,    sck_next;
   logic                sdi_reg,    sdi_next;
   logic                convst_reg, convst_next;
   logic [ADC_BITS-1:0] shift_reg,  shift_next;
   logic                discard_reg, discard_next;
   logic                valid_reg;
   logic                tick;
   logic                load;

   // Free-running frame timer; ticks are ignored outside IDLE.
   assign tick = (period_reg == PERIOD_LAST);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         period_reg <= '0;
      end else if (tick) begin
         period_reg <= '0;
      end else begin
         period_reg <= period_reg + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg   <= IDLE;
         conv_reg    <= '0;
         div_reg     <= '0;
         bit_reg     <= '0;
         sck_reg     <= 1'b0;
         sdi_reg     <= 1'b0;
         convst_reg  <= 1'b0;
         shift_reg   <= '0;
         discard_reg <= 1'b1;
         valid_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         conv_reg    <= conv_next;
         div_reg     <= div_next;
         bit_reg     <= bit_next;
         sck_reg     <= sck_next;
         sdi_reg     <= sdi_next;
         convst_reg  <= convst_next;
         shift_reg   <= shift_next;
         discard_reg <= discard_next;
         valid_reg   <= load;
      end
   end

   // ADC pins are driven from registers computed one state ahead, so they
   // are glitch-free and line up exactly with the state they belong to.
   always_comb begin
      state_next   = state_reg;
      conv_next    = conv_reg;
      div_next     = div_reg;
      bit_next     = bit_reg;
      sck_next     = sck_reg;
      sdi_next     = sdi_reg;
      convst_next  = convst_reg;
      shift_next   = shift_reg;
      discard_next = discard_reg;
      load         = 1'b0;

      case (state_reg)
         IDLE: begin
            convst_next = 1'b0;
            sck_next    = 1'b0;
            sdi_next    = 1'b0;
            if (tick) begin
               state_next  = CONV;
               conv_next   = '0;
               convst_next = 1'b1;
            end
         end

         CONV: begin
            if (conv_reg == CONV_LAST) begin
               state_next  = XFER;
               convst_next = 1'b0;
               div_next    = '0;
               bit_next    = '0;
               sck_next    = 1'b0;
               sdi_next    = SDI_WORD[ADC_BITS-1];
            end else begin
               conv_next = conv_reg + 1'b1;
            end
         end

         XFER: begin
            if (div_reg == DIV_LAST) begin
               div_next = '0;
               sck_next = ~sck_reg;
               // End of a high phase: capture SDO and move SDI on while SCK
               // goes low, so SDI is settled well before the next rise.
               if (sck_reg) begin
                  shift_next = {shift_reg[ADC_BITS-2:0], ADC_SDO};
                  if (bit_reg == 4'd11) begin
                     state_next = DONE;
                     sdi_next   = 1'b0;
                  end else begin
                     bit_next = bit_reg + 4'd1;
                     sdi_next = SDI_WORD[4'd10 - bit_reg];
                  end
               end
            end else begin
               div_next = div_reg + 1'b1;
            end
         end

         DONE: begin
            state_next = IDLE;
            if (discard_reg) begin
               discard_next = 1'b0;
            end else begin
               load = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ADC_CONVST   = convst_reg;
   assign ADC_SCK      = sck_reg;
   assign ADC_SDI      = sdi_reg;
   assign sample_valid = valid_reg;

`ifdef SAMPLER_AVG_EN
   sample_avg4 u_avg (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .load   (load),
      .sample (shift_reg),
      .avg    (ADC_value)
   );
`else
   logic [ADC_BITS-1:0] value_reg;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         value_reg <= '0;
      end else if (load) begin
         value_reg <= shift_reg;
      end
   end

   assign ADC_value = value_reg;
`endif

   // A period shorter than a frame would silently drop every other tick.
   period_fits: assert property (@(posedge CLOCK_50)
      (SAMPLE_PERIOD > FRAME_LEN) && (CLK_DIV >= 1))
      else $error("ltc2308_sampler: SAMPLE_PERIOD too short for one frame");

endmodule

// File: doc/ltc2308_sampler.md
# ltc2308_sampler

Periodic sampler for the LTC2308 SPI ADC that feeds the light-sensor reading to the BCD/seven-segment display stage. It starts a conversion, clocks the 12-bit result out over SPI and presents it as a held `ADC_value` with a one-cycle `sample_valid` strobe. The display stage consumes `ADC_value` directly.

## Interface
- `CLK_DIV`, 2: SCK half-period in clock cycles. Must be ≥1.
- `CONV_CYCLES`, 80: CONVST high time in clocks, covering t_CONV (1.6 µs at 50 MHz).
- `SAMPLE_PERIOD`, 50000: clocks between frame starts (1 kHz at 50 MHz).
- `CHANNEL`, 0: single-ended input channel, 0–7.
- `CLOCK_50`, in, 1: system clock.
- `RESET_N`, in, 1: one clock; reset is asynchronous and active-low.
- `ADC_CONVST`, out, 1: conversion start to the ADC.
- `ADC_SCK`, out, 1: SPI clock. Idles low.
- `ADC_SDI`, out, 1: config word to the ADC.
- `ADC_SDO`, in, 1: result data from the ADC.
- `ADC_value`, out, 12: last accepted sample, unsigned. Held between updates.
- `sample_valid`, out, 1: one-cycle pulse when `ADC_value` updates.

## Operation
- Period counter runs freely from reset over 0..`SAMPLE_PERIOD`-1. Reaching `SAMPLE_PERIOD`-1 emits a tick.
  - A tick in IDLE starts a frame.
  - A tick in any other state is dropped.
  - A simulation assertion requires `SAMPLE_PERIOD` > `CONV_CYCLES` + 24·`CLK_DIV` + 2.
- States: IDLE → CONV → XFER → DONE → IDLE.
  - IDLE: all ADC outputs low.
  - CONV: `ADC_CONVST`=1 for exactly `CONV_CYCLES` clocks, then low. Go to XFER.
  - XFER: 12 SCK periods. Each period is low for `CLK_DIV` clocks, then high for `CLK_DIV` clocks.
  - DONE: one cycle. Latch the result, pulse `sample_valid`, return to IDLE.
- Config word, 6 bits MSB first on `ADC_SDI`: {S/D=1, O/S=CHANNEL[0], S1=CHANNEL[2], S0=CHANNEL[1], UNI=1, SLP=0}.
  - SDI changes only while SCK is low. The bit for period k is stable before rising edge k.
  - SDI=0 for periods 6–11.
- SDO capture:
  - SDO is captured on the clock where SCK is driven 1→0, i.e. at the end of the high phase.
  - It is shifted MSB first into a 12-bit register.
- The LTC2308 applies a config word to the next conversion. The first completed frame after reset is therefore discarded: no `sample_valid`, `ADC_value` unchanged.
- Reset mid-frame:
  - `ADC_CONVST`, `ADC_SCK` and `ADC_SDI` go to 0 immediately.
  - State returns to IDLE, the period counter clears and the discard flag re-arms.

## Timing
- Reset values: `ADC_CONVST`=0, `ADC_SCK`=0, `ADC_SDI`=0, `ADC_value`=0, `sample_valid`=0.
- The first frame starts `SAMPLE_PERIOD` clocks after reset release.
- Frame length is `CONV_CYCLES` + 24·`CLK_DIV` + 1 clocks from tick to DONE.
- `ADC_value` and `sample_valid` change in the same cycle, one clock after the 12th capture.
- `sample_valid` is never high two consecutive cycles.

## Configuration
- `SAMPLER_AVG_EN` defined:
  - `ADC_value` = (sum of the last 4 accepted samples) >> 2, with a 14-bit sum and truncation.
  - The first accepted sample after reset preloads all four history entries.
  - Latency and strobe timing are unchanged.
- Undefined: `ADC_value` = raw sample.

## Structure
- Package `ltc2308_pkg` holds:
  - the state enum (IDLE, CONV, XFER, DONE);
  - the config-bit constants (S/D, UNI, SLP);
  - a function mapping `CHANNEL` to the 6-bit config word.
- One sub-module, `sample_avg4`: 4-entry history, running sum, preload-on-first behaviour. It is instantiated only under `SAMPLER_AVG_EN`.

## Test plan
- Reset, then an SDO model returns 0xABC per frame, with `SAMPLE_PERIOD`=400.
  - Frame 1: no strobe.
  - Frame 2: `ADC_value`=0xABC with a one-cycle `sample_valid`.
  - Frames repeat every 400 clocks.
- `CHANNEL`=5, `CLK_DIV`=2 → SDI bits sampled on SCK rises are 1,1,1,0,1,0,0,0,0,0,0,0. Each SCK phase lasts 2 clocks.
- Check CONVST: high for exactly 80 clocks, then the first SCK rise 2 clocks after it falls. Exactly 12 SCK rises per frame.
- `RESET_N` low during bit 5 of XFER:
  - CONVST/SCK/SDI are 0 within the same cycle.
  - After release, the next frame is discarded and the one after returns correct data.
- `SAMPLER_AVG_EN`, sample sequence 100, 200, 300, 400, 500:
  - outputs 100, 125, 175, 250, 350;
  - the first accepted sample preloads the history.
- `SAMPLE_PERIOD` below the frame length → simulation assertion fires.
